// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, waits a fixed memory latency per fetch,
// captures the returned word into the IR and hands it to decode via valid/ack.
// Branch/jump redirects override everything and abort an in-flight fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_LAT  = 1            // legal 1..16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        ir_ack_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ir_o,
  output logic [31:0] ir_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        ir_valid_o,
  output logic        busy_o,
  output logic        misaligned_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_e;

  // Countdown start value: the capture happens on the cycle where cnt reaches 0.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        err_q, err_d;

  // State register; reset aborts any fetch immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      ir_pc_q    <= 32'd0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: redirect wins over every handshake, then the fetch FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;

    if (redirect_valid_i) begin
      // Drop the low bits so the PC stays word aligned; flag the bad target.
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      ir_valid_d = 1'b0;
      cnt_d      = 4'd0;
      state_d    = IDLE;
      if (redirect_pc_i[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en_i) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            ir_d       = imem_rdata_i;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            ir_valid_d = 1'b1;
            state_d    = VALID;
          end
        end
        VALID: begin
          // An unconsumed IR is never overwritten: fetch_en alone is ignored.
          if (ir_ack_i) begin
            ir_valid_d = 1'b0;
            if (fetch_en_i) begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign imem_addr_o      = pc_q;
  assign ir_o             = ir_q;
  assign ir_pc_o          = ir_pc_q;
  assign pc_plus4_o       = ir_pc_q + 32'd4;
  assign ir_valid_o       = ir_valid_q;
  assign busy_o           = (state_q == WAIT);
  assign misaligned_err_o = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (MEM_LAT=1 and MEM_LAT=4), a directed
// vector table, hand-written corner sequences and a randomized run against a
// timestamp-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fe [2];
  logic        ack [2];
  logic        rv [2];
  logic [31:0] rpc [2];
  logic [31:0] addr [2];
  logic [31:0] rdata [2];
  logic [31:0] ir [2];
  logic [31:0] irpc [2];
  logic [31:0] p4 [2];
  logic        irv [2];
  logic        busy [2];
  logic        err [2];
  logic        ovr_en [2];
  logic [31:0] ovr_val [2];
  logic [31:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instruction memory: word table indexed by address, optional override.
  assign rdata[0] = ovr_en[0] ? ovr_val[0] : mem[addr[0][7:2]];
  assign rdata[1] = ovr_en[1] ? ovr_val[1] : mem[addr[1][7:2]];

  fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fe[0]), .ir_ack_i(ack[0]),
    .redirect_valid_i(rv[0]), .redirect_pc_i(rpc[0]), .imem_addr_o(addr[0]),
    .imem_rdata_i(rdata[0]), .ir_o(ir[0]), .ir_pc_o(irpc[0]), .pc_plus4_o(p4[0]),
    .ir_valid_o(irv[0]), .busy_o(busy[0]), .misaligned_err_o(err[0]));

  fetch_unit #(.RESET_PC(32'h0), .MEM_LAT(4)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fe[1]), .ir_ack_i(ack[1]),
    .redirect_valid_i(rv[1]), .redirect_pc_i(rpc[1]), .imem_addr_o(addr[1]),
    .imem_rdata_i(rdata[1]), .ir_o(ir[1]), .ir_pc_o(irpc[1]), .pc_plus4_o(p4[1]),
    .ir_valid_o(irv[1]), .busy_o(busy[1]), .misaligned_err_o(err[1]));

  typedef struct {
    logic        fe, ack, rv;
    logic [31:0] rpc;
    logic [31:0] addr, ir, irpc, p4;
    logic        v, b, e;
  } row_t;
  row_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input int u, input string tag, input logic [31:0] e_addr,
                         input logic [31:0] e_ir, input logic [31:0] e_irpc,
                         input logic [31:0] e_p4, input logic e_v, input logic e_b,
                         input logic e_e);
    chk({tag, ".imem_addr"}, addr[u], e_addr);
    chk({tag, ".ir"}, ir[u], e_ir);
    chk({tag, ".ir_pc"}, irpc[u], e_irpc);
    chk({tag, ".pc_plus4"}, p4[u], e_p4);
    chk({tag, ".ir_valid"}, 32'(irv[u]), 32'(e_v));
    chk({tag, ".busy"}, 32'(busy[u]), 32'(e_b));
    chk({tag, ".misaligned_err"}, 32'(err[u]), 32'(e_e));
    $display("[TB] %s u%0d addr=%h ir=%h ir_pc=%h v=%0d busy=%0d err=%0d",
             tag, u, addr[u], ir[u], irpc[u], irv[u], busy[u], err[u]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      fe[u] = 1'b0; ack[u] = 1'b0; rv[u] = 1'b0; rpc[u] = 32'd0;
      ovr_en[u] = 1'b0; ovr_val[u] = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state (higher-level: fetch completes at a cycle timestamp).
  logic [31:0] m_pc, m_ir, m_irpc;
  logic        m_valid, m_err, m_inflight;
  int          m_done;

  task automatic model_edge(input int u, input int n, input int lat);
    if (rv[u]) begin
      m_pc = rpc[u] & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_inflight = 1'b0;
      if (rpc[u][1:0] != 2'b00) m_err = 1'b1;
    end else if (m_inflight) begin
      if (n == m_done) begin
        m_ir = mem[m_pc[7:2]];
        m_irpc = m_pc;
        m_pc = m_pc + 32'd4;
        m_valid = 1'b1;
        m_inflight = 1'b0;
      end
    end else if (m_valid) begin
      if (ack[u]) begin
        m_valid = 1'b0;
        if (fe[u]) begin
          m_inflight = 1'b1;
          m_done = n + lat;
        end
      end
    end else if (fe[u]) begin
      m_inflight = 1'b1;
      m_done = n + lat;
    end
  endtask

  initial begin
    logic [31:0] x_ir;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h0022_0000;
    mem[1]  = 32'h0064_0000;
    mem[16] = 32'h1234_5678;
    mem[63] = 32'hDEAD_BEEF;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,  32'h0,         32'h0,  32'h4, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h4,  32'h0022_0000, 32'h0,  32'h4, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4,  32'h0022_0000, 32'h0,  32'h4, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,  32'h0064_0000, 32'h4,  32'h8, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,  32'h0064_0000, 32'h4,  32'h8, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,  32'h0064_0000, 32'h4,  32'h8, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h43,        32'h40, 32'h0064_0000, 32'h4,  32'h8, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h40, 32'h0064_0000, 32'h4,  32'h8, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0064_0000, 32'h4, 32'h8, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0064_0000, 32'h4, 32'h8, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h40,        32'h40, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b1};

    idle_inputs();
    do_reset();
    tick();
    chk_all(0, "reset", 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    chk_all(1, "reset", 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);

    // Directed vector table on the MEM_LAT=1 instance.
    for (int i = 0; i < 12; i++) begin
      fe[0] = tbl[i].fe; ack[0] = tbl[i].ack; rv[0] = tbl[i].rv; rpc[0] = tbl[i].rpc;
      tick();
      chk_all(0, $sformatf("vec%0d", i), tbl[i].addr, tbl[i].ir, tbl[i].irpc,
              tbl[i].p4, tbl[i].v, tbl[i].b, tbl[i].e);
    end
    idle_inputs();

    // MEM_LAT=4: address stable through WAIT, only the cnt==0 data is captured.
    ovr_en[1] = 1'b1; ovr_val[1] = 32'hAAAA_0001;
    fe[1] = 1'b1;
    tick();
    fe[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lat4.wait%0d.addr", k), addr[1], 32'h0);
      chk($sformatf("lat4.wait%0d.busy", k), 32'(busy[1]), 32'd1);
      chk($sformatf("lat4.wait%0d.ir_valid", k), 32'(irv[1]), 32'd0);
      ovr_val[1] = (k == 3) ? 32'hBBBB_0002 : 32'hAAAA_0001 + 32'(k);
      if (k < 3) tick();
    end
    tick();
    chk_all(1, "lat4.capture", 32'h4, 32'hBBBB_0002, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
    ovr_en[1] = 1'b0;

    // Redirect during WAIT drops the fetch; next fetch comes from the target.
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0; fe[1] = 1'b1;
    tick();
    fe[1] = 1'b0;
    tick();
    rv[1] = 1'b1; rpc[1] = 32'h40;
    tick();
    rv[1] = 1'b0;
    chk_all(1, "redir.wait", 32'h40, 32'hBBBB_0002, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk_all(1, "redir.quiet", 32'h40, 32'hBBBB_0002, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    fe[1] = 1'b1;
    tick();
    fe[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_all(1, "redir.fetch", 32'h44, 32'h1234_5678, 32'h40, 32'h44, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect with simultaneous ack; error is sticky over later fetches.
    ack[1] = 1'b1; fe[1] = 1'b1; rv[1] = 1'b1; rpc[1] = 32'h43;
    tick();
    ack[1] = 1'b0; fe[1] = 1'b0; rv[1] = 1'b0;
    chk_all(1, "misalign", 32'h40, 32'h1234_5678, 32'h40, 32'h44, 1'b0, 1'b0, 1'b1);
    fe[1] = 1'b1;
    tick();
    fe[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_all(1, "misalign.sticky", 32'h44, 32'h1234_5678, 32'h40, 32'h44, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-WAIT takes effect before the next clock edge.
    ack[1] = 1'b1; fe[1] = 1'b1;
    tick();
    ack[1] = 1'b0; fe[1] = 1'b0;
    tick();
    chk("prereset.busy", 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all(1, "async_rst", 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    chk_all(0, "async_rst", 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Randomized run on each instance against the reference model.
    for (int u = 0; u < 2; u++) begin
      int lat;
      lat = (u == 0) ? 1 : 4;
      idle_inputs();
      do_reset();
      m_pc = 32'h0; m_ir = 32'h0; m_irpc = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_inflight = 1'b0; m_done = 0;
      for (int n = 0; n < 400; n++) begin
        fe[u]  = ($urandom_range(0, 9) < 7);
        ack[u] = ($urandom_range(0, 1) == 1);
        rv[u]  = ($urandom_range(0, 19) == 0);
        x_ir   = $urandom;
        rpc[u] = ($urandom_range(0, 3) == 0) ? x_ir : (x_ir & 32'hFFFF_FFFC);
        model_edge(u, n, lat);
        tick();
        chk("rnd.addr", addr[u], m_pc);
        chk("rnd.ir", ir[u], m_ir);
        chk("rnd.ir_pc", irpc[u], m_irpc);
        chk("rnd.pc_plus4", p4[u], m_irpc + 32'd4);
        chk("rnd.ir_valid", 32'(irv[u]), 32'(m_valid));
        chk("rnd.busy", 32'(busy[u]), 32'(m_inflight));
        chk("rnd.err", 32'(err[u]), 32'(m_err));
      end
      $display("[TB] random run u%0d (MEM_LAT=%0d) done, failures so far %0d", u, lat, n_fail);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
